// File: rtl/ram_protocol_monitor.sv
// ram_protocol_monitor: watches the SPI-slave RAM command/response stream,
// tracks write/read sequencing and read latency, and reports sticky error
// flags, a saturating error count and the class of the first error.
// Build option: define RAM_MON_SVA_EN to add concurrent assertions/covers.
module ram_protocol_monitor #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TX_TIMEOUT = 4,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [ADDR_WIDTH+1:0] din,
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] dout,
  input  logic                  clr_err,
  output logic [4:0]            err_flags,
  output logic                  err_any,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [2:0]            first_err,
  output logic                  first_err_vld,
  output logic [1:0]            mon_state
);

  localparam int unsigned NUM_ERR = 5;
  localparam int unsigned LAT_W   = 8;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(TX_TIMEOUT - 1);

  // Error class bit positions
  localparam int unsigned E_SEQ_WR  = 0;
  localparam int unsigned E_SEQ_RD  = 1;
  localparam int unsigned E_TX_SPUR = 2;
  localparam int unsigned E_TX_TO   = 3;
  localparam int unsigned E_TX_WID  = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR_ARMED = 2'd1,
    ST_RD_ARMED = 2'd2,
    ST_RD_WAIT  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [LAT_W-1:0]     lat_q, lat_d;
  logic                 tx_q;
  logic [1:0]           cmd;
  logic                 lat_expired;
  logic [NUM_ERR-1:0]   err_vec;
  logic                 new_err;
  logic [2:0]           low_idx;
  logic [NUM_ERR-1:0]   flags_q, flags_d;
  logic [CNT_WIDTH-1:0] count_q, count_d, count_base;
  logic [2:0]           first_q, first_d;
  logic                 fvld_q, fvld_d;
  logic                 any_q;

  assign cmd         = din[ADDR_WIDTH+1:ADDR_WIDTH];
  assign lat_expired = (lat_q == LAT_LAST);

  // Where a command lands when decoded as if the FSM were idle
  function automatic state_e idle_next(input logic [1:0] c);
    unique case (c)
      2'b00:   return ST_WR_ARMED;
      2'b10:   return ST_RD_ARMED;
      default: return ST_IDLE;
    endcase
  endfunction

  // State, latency counter and previous-cycle tx_valid registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lat_q   <= '0;
      tx_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      tx_q    <= tx_valid;
    end
  end

  // Next-state and read-latency counter
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rx_valid) state_d = idle_next(cmd);
      end
      ST_WR_ARMED: begin
        if (rx_valid && cmd != 2'b00) state_d = idle_next(cmd);
      end
      ST_RD_ARMED: begin
        if (rx_valid) begin
          if (cmd == 2'b11) begin
            state_d = ST_RD_WAIT;
            lat_d   = '0;
          end else begin
            state_d = idle_next(cmd);
          end
        end
      end
      ST_RD_WAIT: begin
        if (tx_valid || lat_expired) begin
          state_d = ST_IDLE;
          lat_d   = '0;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Per-cycle violation detection
  always_comb begin
    err_vec = '0;
    err_vec[E_TX_WID]  = tx_valid & tx_q;
    err_vec[E_TX_SPUR] = tx_valid & ~tx_q & (state_q != ST_RD_WAIT);
    err_vec[E_TX_TO]   = (state_q == ST_RD_WAIT) & ~tx_valid & lat_expired;
    if (rx_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          err_vec[E_SEQ_WR] = (cmd == 2'b01);
          err_vec[E_SEQ_RD] = (cmd == 2'b11);
        end
        ST_WR_ARMED: err_vec[E_SEQ_WR] = cmd[1];
        ST_RD_ARMED: err_vec[E_SEQ_RD] = ~cmd[1];
        ST_RD_WAIT:  err_vec[E_SEQ_RD] = 1'b1;
        default:     err_vec = '0;
      endcase
    end
  end

  // Error status next values; a same-cycle error overrides clr_err
  always_comb begin
    new_err = |err_vec;
    low_idx = '0;
    for (int i = NUM_ERR - 1; i >= 0; i--) begin
      if (err_vec[i]) low_idx = 3'(i);
    end
    flags_d    = (clr_err ? '0 : flags_q) | err_vec;
    count_base = clr_err ? '0 : count_q;
    count_d    = count_base;
    if (new_err && (count_base != {CNT_WIDTH{1'b1}})) begin
      count_d = count_base + CNT_WIDTH'(1);
    end
    first_d = clr_err ? 3'd0 : first_q;
    fvld_d  = clr_err ? 1'b0 : fvld_q;
    if (new_err && !fvld_d) begin
      first_d = low_idx;
      fvld_d  = 1'b1;
    end
  end

  // Error status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
      count_q <= '0;
      first_q <= '0;
      fvld_q  <= 1'b0;
      any_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      count_q <= count_d;
      first_q <= first_d;
      fvld_q  <= fvld_d;
      any_q   <= |flags_d;
    end
  end

  assign err_flags     = flags_q;
  assign err_any       = any_q;
  assign err_count     = count_q;
  assign first_err     = first_q;
  assign first_err_vld = fvld_q;
  assign mon_state     = state_q;

  // Payload bits are not inspected by the monitor
  logic unused_payload;
  assign unused_payload = ^din[ADDR_WIDTH-1:0];

`ifdef RAM_MON_SVA_EN
  // One assertion and one cover per error class
  for (genvar g = 0; g < NUM_ERR; g++) begin : g_sva
    a_err: assert property (@(posedge clk) disable iff (rst) !err_vec[g])
      else $error("ram_protocol_monitor: error class %0d detected", g);
    c_err: cover property (@(posedge clk) disable iff (rst) err_vec[g]);
  end

  // Read data must hold while no response is being presented
  a_dout_stable: assert property (@(posedge clk) disable iff (rst)
      (!tx_valid && !$past(tx_valid)) |-> $stable(dout))
    else $error("ram_protocol_monitor: dout changed while tx_valid low");
`else
  logic unused_dout;
  assign unused_dout = ^dout;
`endif

endmodule

// File: doc/ram_protocol_monitor.md
# ram_protocol_monitor

Synthesizable, parametrised protocol monitor for the SPI-slave RAM command interface. It watches the RAM-side `rx_valid`/`din` command stream and the `tx_valid`/`dout` response, and tracks write/read sequencing with a small FSM. It also enforces a bounded read-response latency and a single-cycle `tx_valid` pulse. Errors are reported as registered sticky flags with a saturating error count and first-error capture, so the same checks run in silicon/FPGA and in simulation, alongside the UVM environment.

## Interface
Parameters:
- ADDR_WIDTH, 8, address/payload width; `din` is ADDR_WIDTH+2 bits, command in `din[ADDR_WIDTH+1:ADDR_WIDTH]`
- DATA_WIDTH, 8, width of `dout`
- TX_TIMEOUT, 4, max cycles from accepted read-data command (11) to `tx_valid`; legal range 1..255
- CNT_WIDTH, 8, width of saturating error counter

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- rx_valid  in  1  command/data beat valid on `din`
- din  in  ADDR_WIDTH+2  command (MSBs) + payload
- tx_valid  in  1  RAM read-data valid
- dout  in  DATA_WIDTH  RAM read data; monitored only under the `RAM_MON_SVA_EN` build option
- clr_err  in  1  synchronous clear of error status (not FSM)
- err_flags  out  5  sticky per-class flags: [0] SEQ_WR, [1] SEQ_RD, [2] TX_SPUR, [3] TX_TIMEOUT, [4] TX_WIDTH
- err_any  out  1  OR of err_flags
- err_count  out  CNT_WIDTH  count of cycles with ≥1 new error, saturates at all-ones
- first_err  out  3  lowest-index class of the first erroring cycle since reset/clear
- first_err_vld  out  1  first_err valid
- mon_state  out  2  FSM state: 0 IDLE, 1 WR_ARMED, 2 RD_ARMED, 3 RD_WAIT

## Operation
- A command is accepted on any cycle with `rx_valid` = 1. Its code `cmd` is `din[ADDR_WIDTH+1:ADDR_WIDTH]`.
- IDLE:
  - 00 → WR_ARMED.
  - 10 → RD_ARMED.
  - 01 → SEQ_WR error, stay IDLE.
  - 11 → SEQ_RD error, stay IDLE.
- WR_ARMED:
  - 00 → stay (re-address is legal).
  - 01 → IDLE.
  - 10 or 11 → SEQ_WR error, then process the command as from IDLE (10 → RD_ARMED, 11 → IDLE).
- RD_ARMED:
  - 10 → stay.
  - 11 → RD_WAIT, with the latency counter loaded to 0.
  - 00 or 01 → SEQ_RD error, then process as from IDLE.
- RD_WAIT:
  - Counter increments each cycle.
  - `tx_valid` = 1 → IDLE, no error.
  - Counter reaching TX_TIMEOUT without `tx_valid` → TX_TIMEOUT error, → IDLE.
  - `rx_valid` in RD_WAIT → SEQ_RD error; the command is ignored and the state is kept.
- TX_SPUR: `tx_valid` = 1 in any state other than RD_WAIT. This includes the cycle after RD_WAIT is left via `tx_valid`, unless TX_WIDTH applies.
- TX_WIDTH: `tx_valid` = 1 on two consecutive cycles. It is flagged on the second cycle, which does not also raise TX_SPUR.
- Several classes may fire in one cycle:
  - all corresponding flags set;
  - `err_count` +1 (once per cycle);
  - `first_err` = lowest set index, captured only if `first_err_vld` = 0.
- `clr_err`: next cycle, flags, count and `first_err_vld` are 0. If an error occurs in the same cycle as `clr_err`, the error wins: its flag is set, count = 1, and first_err is captured.
- FSM and latency counter are unaffected by `clr_err`.

## Timing
- Reset values (asynchronous assertion, deassertion synchronous to clk by the integrator):
  - mon_state = IDLE, counter = 0;
  - err_flags = 0, err_any = 0, err_count = 0;
  - first_err = 0, first_err_vld = 0.
- Error outputs are registered: a violation sampled on edge N is visible after edge N.
- mon_state updates on the same edge that samples the command.
- Read latency is legal if `tx_valid` rises 1..TX_TIMEOUT cycles after the edge that accepted 11. A 11 accepted on edge N with no `tx_valid` through edge N+TX_TIMEOUT flags TX_TIMEOUT on edge N+TX_TIMEOUT.
- `tx_valid` on the same edge that accepts 11 is TX_SPUR (state is not yet RD_WAIT).
- Reset mid-RD_WAIT aborts the pending read silently; no error is recorded.

## Configuration
- Macro `RAM_MON_SVA_EN`.
- Defined: the block adds concurrent assertions (`$error`) and cover properties for each error class. They are gated by `disable iff (rst)`. It also asserts `dout` is stable while `tx_valid` = 0 outside reset.
- Undefined: pure synthesizable RTL, no assertions or covers. Port list and register behaviour are identical in both builds.

## Test plan
- Write 00(addr 0x15) then 01(data 0xA5): mon_state 0→1→0; err_flags stay 0x00, err_count 0.
- 10(0x15), 11, `tx_valid` pulse 2 cycles later, TX_TIMEOUT = 4: mon_state 2→3→0; no errors.
- 10, 11, no `tx_valid` for 4 cycles: err_flags = 0x08 on the 4th edge after 11; err_count = 1; first_err = 3; mon_state = IDLE.
- 01 from IDLE in the same cycle as a spurious `tx_valid`: err_flags = 0x05, err_count = 1, first_err = 0.
- RD_WAIT then `tx_valid` high for 2 cycles: err_flags = 0x10 only; then `clr_err` → all status 0 next cycle.
- 300 consecutive SEQ_WR violations with CNT_WIDTH = 8: err_count saturates at 255; first_err stays 0. Assert `rst` mid-RD_WAIT: all outputs 0 immediately.
